// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with show-ahead receive FIFO
//
// Ports:
//   clk          system clock, all logic on rising edge
//   rst_n        synchronous active-low reset
//   uart_rx_pin  asynchronous serial line, idle high
//   rd_en        pop FIFO head this cycle (ignored when empty)
//   err_clr      clear sticky error flags
//   rx_data      FIFO head byte, valid when rx_valid=1
//   rx_valid     FIFO not empty
//   fifo_count   bytes currently buffered, 0..FIFO_DEPTH
//   frame_err    sticky: a stop bit was sampled low
//   overrun      sticky: a byte arrived while the FIFO was full
module uart_receiver #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx_pin,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    // START waits half a bit from the detected falling edge so that every
    // later sample lands near the middle of its bit.
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser (resets to idle-high so reset never fakes a start)
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_pin;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rxs) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt       <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        // Leaving mid-stop-bit lets a back-to-back start bit be seen.
                        state <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    // A held-low line must go high before another frame is accepted.
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic stop_tick;
    logic push;
    logic frame_set;

    assign stop_tick = (state == S_STOP) && (cnt == LAST_CNT);
    assign push      = stop_tick && rxs;
    assign frame_set = stop_tick && !rxs;

    // ------------------------------------------------------------------
    // Show-ahead FIFO and sticky error flags
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          full;
    logic          wr_ok;
    logic          ovr_set;

    assign pop     = rd_en && (count != '0);
    assign full    = (count == FULL_CNT);
    // When full, a same-cycle pop frees the head slot, which is exactly
    // the slot wr_ptr points at, so the push can be accepted.
    assign wr_ok   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
            // A new error in the clearing cycle wins over err_clr.
            frame_err <= frame_set || (frame_err && !err_clr);
            overrun   <= ovr_set   || (overrun   && !err_clr);
        end
    end

    assign rx_data    = mem[rd_ptr];
    assign rx_valid   = (count != '0);
    assign fifo_count = count;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int N       = 8;
    localparam int DEPTH   = 4;
    localparam int H       = N / 2;
    localparam int FRAME   = 10 * N;
    // Posedge index within a frame (1 = first edge after the start bit is driven)
    // at which the stop bit is sampled: 2 synchroniser edges, 1 detect edge,
    // half a bit, then nine full bits.
    localparam int STOP_K  = 3 + H + 9 * N;

    logic       clk;
    logic       rst_n;
    logic       uart_rx_pin;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    logic vhist [1:FRAME];

    uart_receiver #(
        .CLKS_PER_BIT (N),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx_pin (uart_rx_pin),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int cycles);
        uart_rx_pin = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one 8N1 frame; optionally raises rd_en / err_clr for exactly
    // one posedge (frame-relative index k), and records rx_valid per edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pop_k, input int clr_k);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < N; c++) begin
                int k;
                k = i * N + c + 1;
                uart_rx_pin = bits[i];
                rd_en       = (k == pop_k);
                err_clr     = (k == clr_k);
                @(negedge clk);
                vhist[k] = rx_valid;
            end
        end
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rx_valid), 32'd1);
        check(tag, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic [9:0] bits;
        logic       ovr_model;
        int         n;

        uart_rx_pin = 1'b1;
        rd_en       = 1'b0;
        err_clr     = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(2 * N);

        // Single byte, exact rx_valid rise after the stop sample
        send_frame(8'hA5, 1'b1, 0, 0);
        check("t1_valid_before_stop", 32'(vhist[STOP_K - 1]), 32'd0);
        check("t1_valid_after_stop", 32'(vhist[STOP_K]), 32'd1);
        check("t1_data", 32'(rx_data), 32'hA5);
        check("t1_count", 32'(fifo_count), 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t1_valid_after_pop", 32'(rx_valid), 32'd0);
        check("t1_count_after_pop", 32'(fifo_count), 32'd0);

        // Short low glitch on idle line
        uart_rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        idle(3 * N);
        check("t2_count", 32'(fifo_count), 32'd0);
        check("t2_frame_err", 32'(frame_err), 32'd0);
        check("t2_overrun", 32'(overrun), 32'd0);

        // Bad stop bit followed by a long break
        send_frame(8'h3C, 1'b0, 0, 0);
        repeat (10 * N) @(negedge clk);
        check("t3_frame_err", 32'(frame_err), 32'd1);
        check("t3_count", 32'(fifo_count), 32'd0);
        pulse_clr();
        check("t3_frame_err_clr", 32'(frame_err), 32'd0);
        repeat (20 * N) @(negedge clk);
        check("t3_no_repeat_frame", 32'(frame_err), 32'd0);
        idle(2 * N);
        send_frame(8'h41, 1'b1, 0, 0);
        check("t3_count_41", 32'(fifo_count), 32'd1);
        pop_check("t3_data_41", 8'h41);
        check("t3_frame_err_end", 32'(frame_err), 32'd0);

        // Overrun, sticky clear, and set-wins-over-clear
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 0);
        check("t4_count", 32'(fifo_count), 32'd4);
        check("t4_overrun", 32'(overrun), 32'd1);
        pulse_clr();
        check("t4_overrun_clr", 32'(overrun), 32'd0);
        send_frame(8'h06, 1'b1, 0, STOP_K);
        check("t4_set_wins", 32'(overrun), 32'd1);
        check("t4_count_still", 32'(fifo_count), 32'd4);
        pop_check("t4_rd1", 8'h01);
        pop_check("t4_rd2", 8'h02);
        pop_check("t4_rd3", 8'h03);
        pop_check("t4_rd4", 8'h04);
        check("t4_empty", 32'(rx_valid), 32'd0);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t4_underflow_count", 32'(fifo_count), 32'd0);
        check("t4_underflow_frame_err", 32'(frame_err), 32'd0);
        pulse_clr();

        // Full FIFO with pop on the exact push edge
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, 0);
        send_frame(8'h05, 1'b1, STOP_K, 0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd4);
        pop_check("t5_rd1", 8'h02);
        pop_check("t5_rd2", 8'h03);
        pop_check("t5_rd3", 8'h04);
        pop_check("t5_rd4", 8'h05);
        check("t5_empty", 32'(rx_valid), 32'd0);

        // Reset in the middle of data bit 4 of 0x55
        bits = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k <= 5 * N + H; k++) begin
            uart_rx_pin = bits[(k - 1) / N];
            @(negedge clk);
        end
        rst_n       = 1'b0;
        uart_rx_pin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t6_count_rst", 32'(fifo_count), 32'd0);
        check("t6_data_rst", 32'(rx_data), 32'd0);
        check("t6_flags_rst", {30'd0, frame_err, overrun}, 32'd0);
        idle(2 * N);
        send_frame(8'h96, 1'b1, 0, 0);
        check("t6_count", 32'(fifo_count), 32'd1);
        pop_check("t6_data", 8'h96);
        check("t6_empty", 32'(rx_valid), 32'd0);
        check("t6_flags", {30'd0, frame_err, overrun}, 32'd0);

        // Randomised bursts against a queue model of the FIFO
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 6);
            ovr_model = 1'b0;
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1, 0, 0);
                if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else ovr_model = 1'b1;
            end
            check("rnd_count", 32'(fifo_count), 32'(exp_q.size()));
            check("rnd_overrun", 32'(overrun), 32'(ovr_model));
            while (exp_q.size() > 0) pop_check("rnd_data", exp_q.pop_front());
            check("rnd_empty", 32'(rx_valid), 32'd0);
            pulse_clr();
            check("rnd_overrun_clr", 32'(overrun), 32'd0);
            idle($urandom_range(0, N));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive path for the verifuck system: 8N1 deserialiser plus a show-ahead receive FIFO.
- Feeds the CPU's input instruction (`,`) with bytes from the board's RX pin.
- Complements the existing transmit path.
- Runs on the system clock and tolerates CPU stalls by buffering up to FIFO_DEPTH bytes.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per UART bit (12 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- uart_rx_pin  input  1  asynchronous serial line, idle high
- rd_en  input  1  pop FIFO head this cycle
- err_clr  input  1  clear sticky error flags
- rx_data  output  8  FIFO head byte, valid when rx_valid=1
- rx_valid  output  1  FIFO not empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
- frame_err  output  1  sticky: a stop bit sampled low
- overrun  output  1  sticky: a byte was received while FIFO full

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - FSM=IDLE, FIFO empty, rx_valid=0, fifo_count=0, rx_data=0, frame_err=0, overrun=0.
  - Synchroniser flops set to 1.
  - Reset mid-frame abandons the frame; no partial byte is stored.
- Input path:
  - 2-flop synchroniser on uart_rx_pin; all decisions use the synchronised value rxs.
  - Line-to-rxs latency is 2 cycles.
- Bit counter:
  - Counts 0..CLKS_PER_BIT-1.
  - Half-bit point is CLKS_PER_BIT/2 (integer divide).
- FSM states and transitions:
  - IDLE: rxs==0 -> START, counter cleared.
  - START: at the half-bit point, sample rxs.
    - 0 -> DATA, bit index 0, counter cleared.
    - 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: every CLKS_PER_BIT cycles, sample rxs into bit[index], LSB first. After index 7 -> STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - 1: push byte, -> IDLE immediately (mid-stop-bit, allows resync to a back-to-back start).
    - 0: set frame_err, discard byte, -> BREAK.
  - BREAK: wait until rxs==1, then -> IDLE. Prevents a held-low line from producing repeated frames.
- FIFO:
  - Show-ahead: rx_data always shows the head entry.
  - Pushed byte is visible (rx_valid=1, rx_data=byte) the cycle after the stop-sample edge.
  - rd_en with rx_valid=1: head advances at that edge, fifo_count decrements.
  - rd_en with rx_valid=0: ignored, no underflow, no flag.
  - Push while full and rd_en=0: byte dropped, overrun set, FIFO contents unchanged.
  - Push and rd_en in the same cycle:
    - Non-full: count unchanged, ordering preserved.
    - Full: pop first, push accepted, no overrun.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_count ranges 0..FIFO_DEPTH; full when fifo_count==FIFO_DEPTH.
- Error flags:
  - frame_err and overrun are sticky until err_clr=1 (cleared at that edge).
  - If err_clr and a new error occur in the same cycle, the set wins.
  - Errors never block reception.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 8N1 -> rx_valid rises 1 cycle after mid-stop sample, rx_data=0xA5, fifo_count=1; pulse rd_en -> rx_valid=0, fifo_count=0.
- 3-cycle low glitch on idle line -> FSM returns to IDLE, fifo_count stays 0, no flags.
- Send 0x3C with stop bit forced low, line held low for 30 bit times, then high -> exactly one frame_err, FIFO empty. Then send 0x41 -> received correctly; err_clr -> frame_err=0.
- FIFO_DEPTH=4, send 0x01..0x05 back-to-back with rd_en=0 -> fifo_count=4, overrun=1. Reads return 0x01,0x02,0x03,0x04, then rx_valid=0.
- FIFO full, assert rd_en on the exact cycle 0x05 completes -> 0x01 popped, 0x05 stored, overrun=0, fifo_count=4.
- Assert rst_n=0 during DATA bit 4 of 0x55, release, then send 0x96 -> only 0x96 in FIFO, all flags 0.
